complete_arbiter: RTL and testbench

Shares the `CDB_WIDTH` complete-stage broadcast slots among `NUM_FU` functional units (ALUs, multiplier, load, branch) in the R10K pipeline. Each cycle it grants up to `CDB_WIDTH` requesting FUs. The branch FU has fixed top priority; the rest are served by round-robin. Losers receive a per-FU `fu_stall`, which drives the FU's `complete_stall`. Granted packets are registered into the CDB/complete stage one cycle later.

---
 rtl/complete_arbiter_pkg.sv | 32 +++
 rtl/complete_arbiter_picker.sv | 41 ++++
 rtl/complete_arbiter.sv | 107 ++++++++++
 tb/tb_complete_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/complete_arbiter_pkg.sv
// Shared types and defaults for the complete-stage CDB arbiter.
package complete_arbiter_pkg;

  localparam int unsigned NUM_FU_DEF    = 6;
  localparam int unsigned CDB_WIDTH_DEF = 2;
  localparam int unsigned BR_FU_IDX_DEF = NUM_FU_DEF - 1;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned PR_IDX_W  = 6;
  localparam int unsigned XLEN      = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [PR_IDX_W-1:0]  dest_pr;
    logic [XLEN-1:0]      dest_value;
    logic [XLEN-1:0]      target_pc;
    logic                 if_take_branch;
    logic                 halt;
    logic                 valid;
  } FU_COMPLETE_PACKET;

  // Next round-robin start after the last granted FU; the branch FU never owns the pointer.
  function automatic int unsigned rr_next(input int unsigned last,
                                          input int unsigned br_idx,
                                          input int unsigned num_fu);
    int unsigned nxt;
    nxt = (last + 1) % num_fu;
    if (nxt == br_idx) nxt = (nxt + 1) % num_fu;
    return nxt;
  endfunction

endpackage

// File: rtl/complete_arbiter_picker.sv
// Circular request scan from a pointer, filling up to i_num_slots grant slots in order.
module rr_slot_picker
  import complete_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_FU    = NUM_FU_DEF,
  parameter  int unsigned CDB_WIDTH = CDB_WIDTH_DEF,
  localparam int unsigned PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int unsigned SLOT_W    = $clog2(CDB_WIDTH + 1)
) (
  input  logic [NUM_FU-1:0]    i_req,
  input  logic [NUM_FU-1:0]    i_mask,
  input  logic [PTR_W-1:0]     i_ptr,
  input  logic [SLOT_W-1:0]    i_num_slots,
  output logic [NUM_FU-1:0]    o_slot_oh [CDB_WIDTH],
  output logic [CDB_WIDTH-1:0] o_slot_vld,
  output logic                 o_any,
  output logic [PTR_W-1:0]     o_last_idx
);

  always_comb begin
    int unsigned idx;
    int unsigned used;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) o_slot_oh[k] = '0;
    o_slot_vld = '0;
    o_any      = 1'b0;
    o_last_idx = '0;
    used       = 0;
    idx        = 0;
    for (int unsigned s = 0; s < NUM_FU; s++) begin
      idx = (32'(i_ptr) + s) % NUM_FU;
      if (i_req[idx] && i_mask[idx] && (used < 32'(i_num_slots)) && (used < CDB_WIDTH)) begin
        o_slot_oh[used][idx] = 1'b1;
        o_slot_vld[used]     = 1'b1;
        o_any                = 1'b1;
        o_last_idx           = PTR_W'(idx);
        used                 = used + 1;
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Complete-stage arbiter: branch FU fixed into slot 0, remaining CDB slots shared round-robin.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU    = NUM_FU_DEF,
  parameter int unsigned CDB_WIDTH = CDB_WIDTH_DEF,
  parameter int unsigned BR_IDX    = NUM_FU - 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  logic [NUM_FU-1:0]     fu_want,
  input  FU_COMPLETE_PACKET     fu_packet [NUM_FU],
  output logic [NUM_FU-1:0]     fu_stall,
  output logic [CDB_WIDTH-1:0]  cdb_valid,
  output FU_COMPLETE_PACKET     cdb_packet [CDB_WIDTH]
);

  localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SLOT_W = $clog2(CDB_WIDTH + 1);

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 w_arb_en;
  logic                 w_br_grant;
  logic [NUM_FU-1:0]    w_rr_req;
  logic [NUM_FU-1:0]    w_rr_mask;
  logic [SLOT_W-1:0]    w_rr_slots;
  logic [NUM_FU-1:0]    w_pick_oh [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] w_pick_vld;
  logic                 w_pick_any;
  logic [PTR_W-1:0]     w_pick_last;
  logic [NUM_FU-1:0]    w_slot_oh [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] w_slot_vld;
  logic [NUM_FU-1:0]    w_grant;
  FU_COMPLETE_PACKET    w_slot_pkt [CDB_WIDTH];
  logic [PTR_W-1:0]     w_rr_ptr_nxt;

  assign w_arb_en   = ~reset & ~squash;
  assign w_br_grant = w_arb_en & fu_want[BR_IDX];
  assign w_rr_req   = fu_want & {NUM_FU{w_arb_en}};
  assign w_rr_mask  = ~(NUM_FU'(1) << BR_IDX);
  assign w_rr_slots = w_br_grant ? SLOT_W'(CDB_WIDTH - 1) : SLOT_W'(CDB_WIDTH);

  rr_slot_picker #(
    .NUM_FU    (NUM_FU),
    .CDB_WIDTH (CDB_WIDTH)
  ) u_picker (
    .i_req       (w_rr_req),
    .i_mask      (w_rr_mask),
    .i_ptr       (r_rr_ptr),
    .i_num_slots (w_rr_slots),
    .o_slot_oh   (w_pick_oh),
    .o_slot_vld  (w_pick_vld),
    .o_any       (w_pick_any),
    .o_last_idx  (w_pick_last)
  );

  // A branch grant pushes every round-robin pick down by one slot.
  always_comb begin
    for (int unsigned k = 0; k < CDB_WIDTH; k++) w_slot_oh[k] = '0;
    w_slot_vld = '0;
    if (w_br_grant) begin
      w_slot_oh[0][BR_IDX] = 1'b1;
      w_slot_vld[0]        = 1'b1;
      for (int unsigned k = 1; k < CDB_WIDTH; k++) begin
        w_slot_oh[k]  = w_pick_oh[k-1];
        w_slot_vld[k] = w_pick_vld[k-1];
      end
    end else begin
      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        w_slot_oh[k]  = w_pick_oh[k];
        w_slot_vld[k] = w_pick_vld[k];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      w_slot_pkt[k] = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (w_slot_oh[k][i]) w_slot_pkt[k] = w_slot_pkt[k] | fu_packet[i];
      end
      w_grant = w_grant | w_slot_oh[k];
    end
  end

  assign fu_stall     = (squash & ~reset) ? '0 : (fu_want & ~w_grant);
  assign w_rr_ptr_nxt = w_pick_any ? PTR_W'(rr_next(32'(w_pick_last), BR_IDX, NUM_FU)) : r_rr_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      cdb_valid <= '0;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) cdb_packet[k] <= '0;
    end else if (squash) begin
      r_rr_ptr  <= '0;
      cdb_valid <= '0;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) cdb_packet[k] <= '0;
    end else begin
      r_rr_ptr  <= w_rr_ptr_nxt;
      cdb_valid <= w_slot_vld;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) cdb_packet[k] <= w_slot_pkt[k];
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter with NUM_FU=6, CDB_WIDTH=2, BR_IDX=5.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int unsigned NFU = 6;
  localparam int unsigned CW  = 2;
  localparam int unsigned BR  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic [NFU-1:0]    fu_want;
  FU_COMPLETE_PACKET fu_packet [NFU];
  logic [NFU-1:0]    fu_stall;
  logic [CW-1:0]     cdb_valid;
  FU_COMPLETE_PACKET cdb_packet [CW];

  typedef struct packed {
    logic [CW-1:0]                  vld;
    FU_COMPLETE_PACKET [CW-1:0]     pkt;
  } exp_t;

  exp_t              sb [$];
  int unsigned       n_tests = 0;
  int unsigned       n_fail  = 0;
  int unsigned       m_ptr   = 0;
  FU_COMPLETE_PACKET saved_a, saved_b;

  complete_arbiter #(
    .NUM_FU    (NFU),
    .CDB_WIDTH (CW),
    .BR_IDX    (BR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .fu_want    (fu_want),
    .fu_packet  (fu_packet),
    .fu_stall   (fu_stall),
    .cdb_valid  (cdb_valid),
    .cdb_packet (cdb_packet)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic new_pkts();
    for (int i = 0; i < NFU; i++) begin
      fu_packet[i].rob_entry      = ROB_IDX_W'($urandom);
      fu_packet[i].dest_pr        = PR_IDX_W'($urandom);
      fu_packet[i].dest_value     = $urandom;
      fu_packet[i].target_pc      = $urandom;
      fu_packet[i].if_take_branch = 1'($urandom);
      fu_packet[i].halt           = 1'b0;
      fu_packet[i].valid          = 1'b1;
    end
  endtask

  // Called just after a posedge: drives requests, checks fu_stall, queues the registered result.
  task automatic drive(input logic [NFU-1:0] want, input logic sq);
    exp_t           e;
    logic [NFU-1:0] stall;
    int unsigned    p, used, last;
    bit             any;
    fu_want = want;
    squash  = sq;
    #3;
    e     = '0;
    stall = want;
    used  = 0;
    last  = 0;
    any   = 1'b0;
    if (reset) begin
      m_ptr = 0;
    end else if (sq) begin
      stall = '0;
      m_ptr = 0;
    end else begin
      if (want[BR]) begin
        e.vld[0]  = 1'b1;
        e.pkt[0]  = fu_packet[BR];
        stall[BR] = 1'b0;
        used      = 1;
      end
      p = m_ptr;
      for (int s = 0; s < NFU; s++) begin
        if (p != BR && want[p] && used < CW) begin
          e.vld[used] = 1'b1;
          e.pkt[used] = fu_packet[p];
          stall[p]    = 1'b0;
          used++;
          last = p;
          any  = 1'b1;
        end
        p = (p == NFU - 1) ? 0 : p + 1;
      end
      if (any) m_ptr = (last + 1 == BR) ? (BR + 1) % NFU : (last + 1) % NFU;
    end
    check_eq("fu_stall", 96'(fu_stall), 96'(stall));
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    check_eq("sb_depth", 96'(sb.size()), 96'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("cdb_valid", 96'(cdb_valid), 96'(e.vld));
      for (int k = 0; k < CW; k++)
        check_eq($sformatf("cdb_packet[%0d]", k), 96'(cdb_packet[k]), 96'(e.pkt[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    squash  = 1'b0;
    fu_want = '1;
    new_pkts();
    #1 reset = 1'b1;
    #1;
    check_eq("rst_cdb_valid", 96'(cdb_valid), 96'd0);
    check_eq("rst_cdb_pkt0", 96'(cdb_packet[0]), 96'd0);
    check_eq("rst_cdb_pkt1", 96'(cdb_packet[1]), 96'd0);
    check_eq("rst_fu_stall", 96'(fu_stall), 96'(6'b111111));
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // First post-reset grants: branch FU5 then FU0.
    new_pkts();
    saved_a = fu_packet[5];
    saved_b = fu_packet[0];
    drive(6'b111111, 1'b0);
    check_eq("t1_stall", 96'(fu_stall), 96'(6'b011110));
    step();
    check_eq("t1_slot0", 96'(cdb_packet[0]), 96'(saved_a));
    check_eq("t1_slot1", 96'(cdb_packet[1]), 96'(saved_b));

    // Squash to bring the pointer back to 0.
    new_pkts();
    drive(6'b111111, 1'b1);
    check_eq("sq_stall", 96'(fu_stall), 96'd0);
    step();
    check_eq("sq_cdb_valid", 96'(cdb_valid), 96'd0);

    new_pkts();
    fu_packet[5].rob_entry      = 5'd7;
    fu_packet[5].target_pc      = 32'd8;
    fu_packet[5].if_take_branch = 1'b1;
    saved_b = fu_packet[0];
    drive(6'b100111, 1'b0);
    check_eq("t2_stall", 96'(fu_stall), 96'(6'b000110));
    step();
    check_eq("t2_rob", 96'(cdb_packet[0].rob_entry), 96'd7);
    check_eq("t2_tpc", 96'(cdb_packet[0].target_pc), 96'd8);
    check_eq("t2_slot1", 96'(cdb_packet[1]), 96'(saved_b));

    new_pkts();
    saved_a = fu_packet[1];
    saved_b = fu_packet[2];
    drive(6'b000110, 1'b0);
    check_eq("t3_stall", 96'(fu_stall), 96'd0);
    step();
    check_eq("t3_slot0", 96'(cdb_packet[0]), 96'(saved_a));
    check_eq("t3_slot1", 96'(cdb_packet[1]), 96'(saved_b));

    // Pointer sits at 3; the scan wraps past 4 to reach FU0 and FU1.
    new_pkts();
    saved_a = fu_packet[0];
    saved_b = fu_packet[1];
    drive(6'b000011, 1'b0);
    step();
    check_eq("t4_slot0", 96'(cdb_packet[0]), 96'(saved_a));
    check_eq("t4_slot1", 96'(cdb_packet[1]), 96'(saved_b));

    new_pkts();
    drive(6'b000000, 1'b0);
    step();
    check_eq("idle_valid", 96'(cdb_valid), 96'd0);

    for (int n = 0; n < 80; n++) begin
      new_pkts();
      drive(NFU'($urandom), ($urandom_range(0, 9) == 0));
      step();
    end

    new_pkts();
    drive(6'b111111, 1'b0);
    step();
    check_eq("t6_pre_valid", 96'(cdb_valid), 96'(2'b11));
    #1 reset = 1'b1;
    #1;
    m_ptr = 0;
    check_eq("t6_async_valid", 96'(cdb_valid), 96'd0);
    check_eq("t6_async_pkt0", 96'(cdb_packet[0]), 96'd0);
    check_eq("t6_async_pkt1", 96'(cdb_packet[1]), 96'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    new_pkts();
    saved_a = fu_packet[3];
    saved_b = fu_packet[4];
    drive(6'b011000, 1'b0);
    step();
    check_eq("t6_slot0", 96'(cdb_packet[0]), 96'(saved_a));
    check_eq("t6_slot1", 96'(cdb_packet[1]), 96'(saved_b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
